// File: rtl/inst_decode_queue.sv
`default_nettype none
// ============================================================================
// inst_decode_queue - circular fetch/issue buffer with per-slot decode and
// dual-issue pairing. Optional macro: DECODE_QUEUE_PERF_EN (issue counters).
// Rev 1.0
// ============================================================================

module idq_decoder (
  input  logic [31:0] i_instr,
  output logic [7:0]  o_aluop,
  output logic        o_reg_wen,
  output logic [4:0]  o_reg_waddr,
  output logic [3:0]  o_branch_type,
  output logic        o_is_link_pc8,
  output logic        o_is_only_master,
  output logic        o_is_hilo_accessed,
  output logic        o_mem_en,
  output logic        o_spec_inst,
  output logic        o_eret_inst,
  output logic        o_undefined_inst
);
  localparam logic [3:0] c_BT_NOP    = 4'd0;
  localparam logic [3:0] c_BT_BEQ    = 4'd1;
  localparam logic [3:0] c_BT_BNE    = 4'd2;
  localparam logic [3:0] c_BT_BLEZ   = 4'd3;
  localparam logic [3:0] c_BT_BGTZ   = 4'd4;
  localparam logic [3:0] c_BT_BLTZ   = 4'd5;
  localparam logic [3:0] c_BT_BGEZ   = 4'd6;
  localparam logic [3:0] c_BT_BLTZAL = 4'd7;
  localparam logic [3:0] c_BT_BGEZAL = 4'd8;
  localparam logic [3:0] c_BT_J      = 4'd9;
  localparam logic [3:0] c_BT_JAL    = 4'd10;
  localparam logic [3:0] c_BT_JR     = 4'd11;
  localparam logic [3:0] c_BT_JALR   = 4'd12;

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [4:0] w_rd;

  assign w_op    = i_instr[31:26];
  assign w_rs    = i_instr[25:21];
  assign w_rt    = i_instr[20:16];
  assign w_rd    = i_instr[15:11];
  assign w_funct = i_instr[5:0];

  always_comb begin
    o_aluop            = 8'h00;
    o_reg_wen          = 1'b0;
    o_reg_waddr        = 5'd0;
    o_branch_type      = c_BT_NOP;
    o_is_link_pc8      = 1'b0;
    o_is_only_master   = 1'b0;
    o_is_hilo_accessed = 1'b0;
    o_mem_en           = 1'b0;
    o_spec_inst        = 1'b0;
    o_eret_inst        = 1'b0;
    o_undefined_inst   = 1'b0;
    case (w_op)
      6'h00: begin
        o_aluop = {2'b01, w_funct};
        case (w_funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
          6'h26, 6'h27, 6'h2A, 6'h2B: begin
            o_reg_wen   = 1'b1;
            o_reg_waddr = w_rd;
          end
          6'h08: o_branch_type = c_BT_JR;
          6'h09: begin
            o_branch_type = c_BT_JALR;
            o_reg_wen     = 1'b1;
            o_reg_waddr   = w_rd;
            o_is_link_pc8 = 1'b1;
          end
          6'h0C, 6'h0D: o_spec_inst = 1'b1;
          6'h10, 6'h12: begin
            o_is_hilo_accessed = 1'b1;
            o_reg_wen          = 1'b1;
            o_reg_waddr        = w_rd;
          end
          6'h11, 6'h13: o_is_hilo_accessed = 1'b1;
          // Multi-cycle multiply/divide units sit on the master pipe only
          6'h18, 6'h19, 6'h1A, 6'h1B: begin
            o_is_hilo_accessed = 1'b1;
            o_is_only_master   = 1'b1;
          end
          default: begin
            o_aluop          = 8'h00;
            o_undefined_inst = 1'b1;
          end
        endcase
      end
      6'h01: begin
        o_aluop = {3'b110, w_rt};
        case (w_rt)
          5'h00: o_branch_type = c_BT_BLTZ;
          5'h01: o_branch_type = c_BT_BGEZ;
          5'h10, 5'h11: begin
            o_branch_type = (w_rt == 5'h10) ? c_BT_BLTZAL : c_BT_BGEZAL;
            o_reg_wen     = 1'b1;
            o_reg_waddr   = 5'd31;
            o_is_link_pc8 = 1'b1;
          end
          default: begin
            o_aluop          = 8'h00;
            o_undefined_inst = 1'b1;
          end
        endcase
      end
      6'h02: begin
        o_aluop       = {2'b10, w_op};
        o_branch_type = c_BT_J;
      end
      6'h03: begin
        o_aluop       = {2'b10, w_op};
        o_branch_type = c_BT_JAL;
        o_reg_wen     = 1'b1;
        o_reg_waddr   = 5'd31;
        o_is_link_pc8 = 1'b1;
      end
      6'h04, 6'h05, 6'h06, 6'h07: begin
        o_aluop = {2'b10, w_op};
        case (w_op[1:0])
          2'd0:    o_branch_type = c_BT_BEQ;
          2'd1:    o_branch_type = c_BT_BNE;
          2'd2:    o_branch_type = c_BT_BLEZ;
          default: o_branch_type = c_BT_BGTZ;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        o_aluop     = {2'b10, w_op};
        o_reg_wen   = 1'b1;
        o_reg_waddr = w_rt;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        o_aluop     = {2'b10, w_op};
        o_mem_en    = 1'b1;
        o_reg_wen   = 1'b1;
        o_reg_waddr = w_rt;
      end
      6'h28, 6'h29, 6'h2B: begin
        o_aluop  = {2'b10, w_op};
        o_mem_en = 1'b1;
      end
      6'h10: begin
        o_aluop = {2'b10, w_op};
        if (i_instr == 32'h4200_0018) begin
          o_eret_inst      = 1'b1;
          o_is_only_master = 1'b1;
        end else if (w_rs == 5'h00) begin
          o_spec_inst      = 1'b1;
          o_is_only_master = 1'b1;
          o_reg_wen        = 1'b1;
          o_reg_waddr      = w_rt;
        end else if (w_rs == 5'h04) begin
          o_spec_inst      = 1'b1;
          o_is_only_master = 1'b1;
        end else begin
          o_aluop          = 8'h00;
          o_undefined_inst = 1'b1;
        end
      end
      default: o_undefined_inst = 1'b1;
    endcase
  end
endmodule

module inst_decode_queue #(
  parameter int DEPTH   = 16,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic [FETCH_W-1:0]     in_valid,
  input  logic [32*FETCH_W-1:0]  in_instr,
  input  logic [32*FETCH_W-1:0]  in_pc,
  output logic                   in_ready,
  input  logic                   issue_ready,
  output logic [ISSUE_W-1:0]     out_valid,
  output logic [32*ISSUE_W-1:0]  out_instr,
  output logic [32*ISSUE_W-1:0]  out_pc,
  output logic [8*ISSUE_W-1:0]   out_aluop,
  output logic [5*ISSUE_W-1:0]   out_reg_waddr,
  output logic [4*ISSUE_W-1:0]   out_branch_type,
  output logic [31:0]            perf_dual_cnt,
  output logic [31:0]            perf_single_cnt
);
  localparam int              PTR_W     = $clog2(DEPTH);
  localparam int              CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_DEPTH   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_FETCH_W = CNT_W'(FETCH_W);
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
  localparam logic [3:0]       c_BT_NOP  = 4'd0;

  logic [31:0]      r_instr [DEPTH];
  logic [31:0]      r_pc    [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic [CNT_W-1:0] w_push_cnt;
  logic [CNT_W-1:0] w_push_eff;
  logic [1:0]       w_n;

  logic [31:0] w_head_instr   [ISSUE_W];
  logic [31:0] w_head_pc      [ISSUE_W];
  logic [7:0]  w_aluop        [ISSUE_W];
  logic        w_reg_wen      [ISSUE_W];
  logic [4:0]  w_reg_waddr    [ISSUE_W];
  logic [3:0]  w_branch_type  [ISSUE_W];
  logic        w_link         [ISSUE_W];
  logic        w_only_master  [ISSUE_W];
  logic        w_hilo         [ISSUE_W];
  logic        w_mem_en       [ISSUE_W];
  logic        w_spec         [ISSUE_W];
  logic        w_eret         [ISSUE_W];
  logic        w_undef        [ISSUE_W];

  assign in_ready   = (c_DEPTH - r_count) >= c_FETCH_W;
  assign w_push     = in_valid[0] && in_ready && !flush;
  assign w_push_eff = w_push ? w_push_cnt : '0;

  always_comb begin
    w_push_cnt = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      w_push_cnt = w_push_cnt + CNT_W'(in_valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (in_valid[i]) begin
          r_instr[r_wr_ptr + PTR_W'(i)] <= in_instr[32*i +: 32];
          r_pc[r_wr_ptr + PTR_W'(i)]    <= in_pc[32*i +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_n);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + w_push_cnt[PTR_W-1:0];
      end
      r_count <= r_count + w_push_eff - CNT_W'(w_n);
    end
  end

  genvar s;
  generate
    for (s = 0; s < ISSUE_W; s++) begin : g_slot
      assign w_head_instr[s] = r_instr[r_rd_ptr + PTR_W'(s)];
      assign w_head_pc[s]    = r_pc[r_rd_ptr + PTR_W'(s)];

      idq_decoder u_dec (
        .i_instr            (w_head_instr[s]),
        .o_aluop            (w_aluop[s]),
        .o_reg_wen          (w_reg_wen[s]),
        .o_reg_waddr        (w_reg_waddr[s]),
        .o_branch_type      (w_branch_type[s]),
        .o_is_link_pc8      (w_link[s]),
        .o_is_only_master   (w_only_master[s]),
        .o_is_hilo_accessed (w_hilo[s]),
        .o_mem_en           (w_mem_en[s]),
        .o_spec_inst        (w_spec[s]),
        .o_eret_inst        (w_eret[s]),
        .o_undefined_inst   (w_undef[s])
      );

      assign out_valid[s]             = (w_n > 2'(s));
      assign out_instr[32*s +: 32]    = w_head_instr[s];
      assign out_pc[32*s +: 32]       = w_head_pc[s];
      assign out_aluop[8*s +: 8]      = w_aluop[s];
      assign out_reg_waddr[5*s +: 5]  = w_reg_waddr[s];
      assign out_branch_type[4*s +: 4] = w_branch_type[s];
    end

    if (ISSUE_W == 2) begin : g_dual
      logic w_raw;

      assign w_raw = w_reg_wen[0] && (w_reg_waddr[0] != 5'd0) &&
                     ((w_reg_waddr[0] == w_head_instr[1][25:21]) ||
                      (w_reg_waddr[0] == w_head_instr[1][20:16]));

      always_comb begin
        w_n = 2'd0;
        if (flush || !issue_ready || (r_count == '0)) begin
          w_n = 2'd0;
        end else if (w_branch_type[0] != c_BT_NOP) begin
          // A branch never leaves without its delay slot; only a link write
          // consumed by that delay slot splits the pair.
          if (r_count == c_ONE) begin
            w_n = 2'd0;
          end else if (w_link[0] && w_raw) begin
            w_n = 2'd1;
          end else begin
            w_n = 2'd2;
          end
        end else if ((r_count == c_ONE) || w_only_master[1] ||
                     (w_branch_type[1] != c_BT_NOP) || w_raw ||
                     (w_hilo[0] && w_hilo[1]) || (w_mem_en[0] && w_mem_en[1]) ||
                     w_spec[0] || w_spec[1] || w_eret[0] || w_eret[1] ||
                     w_undef[0] || w_undef[1]) begin
          w_n = 2'd1;
        end else begin
          w_n = 2'd2;
        end
      end
    end else begin : g_single
      always_comb begin
        w_n = 2'd0;
        if (flush || !issue_ready || (r_count == '0)) begin
          w_n = 2'd0;
        end else if ((w_branch_type[0] != c_BT_NOP) && (r_count == c_ONE)) begin
          w_n = 2'd0;
        end else begin
          w_n = 2'd1;
        end
      end
    end
  endgenerate

`ifdef DECODE_QUEUE_PERF_EN
  logic [31:0] r_perf_dual;
  logic [31:0] r_perf_single;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perf_dual   <= '0;
      r_perf_single <= '0;
    end else begin
      if ((w_n == 2'd2) && (r_perf_dual != 32'hFFFF_FFFF)) begin
        r_perf_dual <= r_perf_dual + 32'd1;
      end
      if ((w_n == 2'd1) && (r_perf_single != 32'hFFFF_FFFF)) begin
        r_perf_single <= r_perf_single + 32'd1;
      end
    end
  end

  assign perf_dual_cnt   = r_perf_dual;
  assign perf_single_cnt = r_perf_single;
`else
  assign perf_dual_cnt   = 32'd0;
  assign perf_single_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_decode_queue.sv
`default_nettype none
// ============================================================================
// tb_inst_decode_queue - directed and randomized checks against a queue model.
// Rev 1.0
// ============================================================================

module tb_inst_decode_queue;
  localparam int K_ADDU = 0, K_SUBU = 1, K_OR = 2, K_ORI = 3, K_LW = 4, K_SW = 5,
                 K_BEQ = 6, K_JAL = 7, K_MULT = 8, K_MFLO = 9, K_SYSCALL = 10,
                 K_UNDEF = 11, K_JR = 12, K_BLTZAL = 13, K_ERET = 14;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  waddr;
    logic [3:0]  bt;
    logic        hilo;
    logic        mem;
    logic        om;
    logic        spec;
    logic        eret;
    logic        undef;
    logic        link;
  } ent_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  in_valid = 2'b00;
  logic [63:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  logic        in_ready;
  logic        issue_ready = 1'b0;
  logic [1:0]  out_valid;
  logic [63:0] out_instr;
  logic [63:0] out_pc;
  logic [15:0] out_aluop;
  logic [9:0]  out_reg_waddr;
  logic [7:0]  out_branch_type;
  logic [31:0] perf_dual_cnt;
  logic [31:0] perf_single_cnt;

  ent_t        q[$];
  ent_t        cur_e0, cur_e1;
  logic [31:0] pc_next = 32'h0000_1000;
  int          m_dual = 0;
  int          m_single = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  inst_decode_queue #(.DEPTH(16), .FETCH_W(2), .ISSUE_W(2)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_instr        (in_instr),
    .in_pc           (in_pc),
    .in_ready        (in_ready),
    .issue_ready     (issue_ready),
    .out_valid       (out_valid),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_aluop       (out_aluop),
    .out_reg_waddr   (out_reg_waddr),
    .out_branch_type (out_branch_type),
    .perf_dual_cnt   (perf_dual_cnt),
    .perf_single_cnt (perf_single_cnt)
  );

  always #5 clk = ~clk;

  function automatic ent_t mk(input int kind, input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] c);
    ent_t e;
    e = '0;
    e.pc = pc_next;
    pc_next = pc_next + 32'd4;
    case (kind)
      K_ADDU:    begin e.instr = {6'h00, b, c, a, 5'h0, 6'h21}; e.wen = 1; e.waddr = a; end
      K_SUBU:    begin e.instr = {6'h00, b, c, a, 5'h0, 6'h23}; e.wen = 1; e.waddr = a; end
      K_OR:      begin e.instr = {6'h00, b, c, a, 5'h0, 6'h25}; e.wen = 1; e.waddr = a; end
      K_ORI:     begin e.instr = {6'h0D, b, a, 16'h1234}; e.wen = 1; e.waddr = a; end
      K_LW:      begin e.instr = {6'h23, b, a, 16'h0010}; e.mem = 1; e.wen = 1; e.waddr = a; end
      K_SW:      begin e.instr = {6'h2B, b, a, 16'h0010}; e.mem = 1; end
      K_BEQ:     begin e.instr = {6'h04, b, c, 16'h0004}; e.bt = 4'd1; end
      K_JAL:     begin e.instr = {6'h03, 26'h0000100}; e.bt = 4'd10; e.wen = 1; e.waddr = 5'd31; e.link = 1; end
      K_MULT:    begin e.instr = {6'h00, b, c, 10'h0, 6'h18}; e.hilo = 1; e.om = 1; end
      K_MFLO:    begin e.instr = {6'h00, 10'h0, a, 5'h0, 6'h12}; e.hilo = 1; e.wen = 1; e.waddr = a; end
      K_SYSCALL: begin e.instr = 32'h0000_000C; e.spec = 1; end
      K_UNDEF:   begin e.instr = {6'h3F, b, c, 16'h0}; e.undef = 1; end
      K_JR:      begin e.instr = {6'h00, b, 15'h0, 6'h08}; e.bt = 4'd11; end
      K_BLTZAL:  begin e.instr = {6'h01, b, 5'h10, 16'h0004}; e.bt = 4'd7; e.wen = 1; e.waddr = 5'd31; e.link = 1; end
      default:   begin e.instr = 32'h4200_0018; e.eret = 1; e.om = 1; end
    endcase
    return e;
  endfunction

  function automatic logic [4:0] rnd_reg();
    int r;
    r = $urandom_range(0, 7);
    return (r == 7) ? 5'd31 : 5'(r);
  endfunction

  function automatic bit writes_src(input ent_t p, input ent_t c);
    return p.wen && (p.waddr != 5'd0) &&
           ((p.waddr == c.instr[25:21]) || (p.waddr == c.instr[20:16]));
  endfunction

  // Issue count straight from the pairing rules applied to the model queue
  function automatic int model_n(input logic ir, input logic fl);
    if (fl || !ir || (q.size() == 0)) return 0;
    if (q[0].bt != 4'd0) begin
      if (q.size() == 1) return 0;
      if (q[0].link && writes_src(q[0], q[1])) return 1;
      return 2;
    end
    if (q.size() == 1) return 1;
    if (q[1].om || (q[1].bt != 4'd0) || writes_src(q[0], q[1])) return 1;
    if ((q[0].hilo && q[1].hilo) || (q[0].mem && q[1].mem)) return 1;
    if (q[0].spec || q[1].spec || q[0].eret || q[1].eret) return 1;
    if (q[0].undef || q[1].undef) return 1;
    return 2;
  endfunction

  function automatic logic [1:0] mask_of(input int n);
    return (n == 2) ? 2'b11 : ((n == 1) ? 2'b01 : 2'b00);
  endfunction

  function automatic logic [31:0] exp_dual();
`ifdef DECODE_QUEUE_PERF_EN
    return 32'(m_dual);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_single();
`ifdef DECODE_QUEUE_PERF_EN
    return 32'(m_single);
`else
    return 32'd0;
`endif
  endfunction

  task automatic drive(input logic fl, input logic [1:0] iv, input logic ir,
                       input ent_t e0, input ent_t e1);
    flush       = fl;
    in_valid    = iv;
    issue_ready = ir;
    in_instr    = {e1.instr, e0.instr};
    in_pc       = {e1.pc, e0.pc};
    cur_e0      = e0;
    cur_e1      = e1;
  endtask

  task automatic advance();
    int  n;
    bit  rdy;
    n   = model_n(issue_ready, flush);
    rdy = (16 - q.size()) >= 2;
    if (flush) begin
      q.delete();
    end else begin
      if (n == 2) m_dual++;
      if (n == 1) m_single++;
      for (int i = 0; i < n; i++) void'(q.pop_front());
      if (in_valid[0] && rdy) begin
        q.push_back(cur_e0);
        if (in_valid[1]) q.push_back(cur_e1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ent_t z;
    z = '0;
    drive(1'b0, 2'b00, 1'b0, z, z);
    resetn = 1'b0;
    q.delete();
    m_dual = 0;
    m_single = 0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    ent_t z;
    z = '0;
    drive(1'b0, 2'b00, 1'b1, z, z);
    resetn = 1'b0;
    #3;
    n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 00", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (perf_dual_cnt !== 32'd0 || perf_single_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_dual_cnt, perf_single_cnt);
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    q.delete();
  endtask

  task automatic test_pair_basic();
    ent_t e0, e1, z;
    z = '0;
    e0 = mk(K_ADDU, 5'd3, 5'd1, 5'd2);
    e1 = mk(K_OR, 5'd5, 5'd4, 5'd6);
    drive(1'b0, 2'b11, 1'b1, e0, e1);
    @(negedge clk);
    n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL pair_empty_valid: got %b expected 00", out_valid); end
    advance();
    drive(1'b0, 2'b00, 1'b1, z, z);
    @(negedge clk);
    n_checks++; if (out_valid !== 2'b11) begin n_fail++; $display("FAIL pair_valid: got %b expected 11", out_valid); end
    n_checks++; if (out_pc !== {e1.pc, e0.pc}) begin n_fail++; $display("FAIL pair_pc: got %h expected %h", out_pc, {e1.pc, e0.pc}); end
    n_checks++; if (out_reg_waddr !== {5'd5, 5'd3}) begin n_fail++; $display("FAIL pair_waddr: got %h expected %h", out_reg_waddr, {5'd5, 5'd3}); end
    n_checks++; if (out_instr !== {e1.instr, e0.instr}) begin n_fail++; $display("FAIL pair_instr: got %h expected %h", out_instr, {e1.instr, e0.instr}); end
    advance();
    @(negedge clk);
    n_checks++; if (out_valid !== 2'b00 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL pair_drained: got valid %b ready %b expected 00/1", out_valid, in_ready);
    end
    advance();
  endtask

  task automatic test_raw();
    ent_t e0, e1, z;
    z = '0;
    e0 = mk(K_ADDU, 5'd3, 5'd1, 5'd2);
    e1 = mk(K_SUBU, 5'd4, 5'd3, 5'd1);
    drive(1'b0, 2'b11, 1'b1, e0, e1);
    advance();
    drive(1'b0, 2'b00, 1'b1, z, z);
    @(negedge clk);
    n_checks++; if (out_valid !== 2'b01 || out_pc[31:0] !== e0.pc) begin
      n_fail++; $display("FAIL raw_first: got %b pc %h expected 01 pc %h", out_valid, out_pc[31:0], e0.pc);
    end
    advance();
    @(negedge clk);
    n_checks++; if (out_valid !== 2'b01 || out_pc[31:0] !== e1.pc || out_reg_waddr[4:0] !== 5'd4) begin
      n_fail++; $display("FAIL raw_second: got %b pc %h wa %0d expected 01 pc %h wa 4", out_valid, out_pc[31:0], out_reg_waddr[4:0], e1.pc);
    end
    advance();
  endtask

  task automatic test_branch_hold();
    ent_t br, ds, z;
    z = '0;
    br = mk(K_BEQ, 5'd0, 5'd1, 5'd2);
    drive(1'b0, 2'b01, 1'b1, br, z);
    advance();
    ds = mk(K_ADDU, 5'd7, 5'd8, 5'd9);
    drive(1'b0, 2'b01, 1'b1, ds, z);
    @(negedge clk);
    n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL branch_held: got %b expected 00", out_valid); end
    advance();
    drive(1'b0, 2'b00, 1'b1, z, z);
    @(negedge clk);
    n_checks++; if (out_valid !== 2'b11 || out_branch_type[3:0] !== 4'd1) begin
      n_fail++; $display("FAIL branch_pair: got %b bt %0d expected 11 bt 1", out_valid, out_branch_type[3:0]);
    end
    n_checks++; if (out_pc !== {ds.pc, br.pc}) begin n_fail++; $display("FAIL branch_pair_pc: got %h expected %h", out_pc, {ds.pc, br.pc}); end
    advance();
  endtask

  task automatic test_full_wrap();
    ent_t e0, e1, z;
    int   drained;
    int   en;
    z = '0;
    drained = 0;
    for (int g = 0; g < 9; g++) begin
      e0 = mk(K_OR, 5'(8 + g % 8), 5'd16, 5'd17);
      e1 = mk(K_OR, 5'(8 + (g + 4) % 8), 5'd18, 5'd19);
      drive(1'b0, 2'b11, 1'b0, e0, e1);
      @(negedge clk);
      n_checks++; if (in_ready !== (g < 8)) begin n_fail++; $display("FAIL full_in_ready[%0d]: got %b expected %b", g, in_ready, (g < 8)); end
      advance();
    end
    drive(1'b0, 2'b00, 1'b1, z, z);
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      @(negedge clk);
      en = model_n(1'b1, 1'b0);
      n_checks++; if (out_valid !== mask_of(en)) begin n_fail++; $display("FAIL drain_valid: got %b expected %b", out_valid, mask_of(en)); end
      for (int s = 0; s < en; s++) begin
        n_checks++; if (out_pc[32*s +: 32] !== q[s].pc) begin
          n_fail++; $display("FAIL drain_pc[%0d]: got %h expected %h", s, out_pc[32*s +: 32], q[s].pc);
        end
      end
      drained += int'(out_valid[0]) + int'(out_valid[1]);
      advance();
    end
    n_checks++; if (drained != 16) begin n_fail++; $display("FAIL drain_total: got %0d expected 16", drained); end
  endtask

  task automatic test_flush();
    ent_t z;
    z = '0;
    for (int g = 0; g < 3; g++) begin
      drive(1'b0, 2'b11, 1'b0, mk(K_ADDU, 5'd1, 5'd2, 5'd3), mk(K_ORI, 5'd4, 5'd5, 5'd0));
      advance();
    end
    drive(1'b1, 2'b11, 1'b1, mk(K_OR, 5'd8, 5'd9, 5'd10), mk(K_OR, 5'd11, 5'd12, 5'd13));
    @(negedge clk);
    n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL flush_same_cycle: got %b expected 00", out_valid); end
    advance();
    drive(1'b0, 2'b00, 1'b1, z, z);
    @(negedge clk);
    n_checks++; if (out_valid !== 2'b00 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_after: got valid %b ready %b expected 00/1", out_valid, in_ready);
    end
    n_checks++; if (perf_dual_cnt !== exp_dual() || perf_single_cnt !== exp_single()) begin
      n_fail++; $display("FAIL flush_perf: got %0d/%0d expected %0d/%0d", perf_dual_cnt, perf_single_cnt, exp_dual(), exp_single());
    end
    advance();
  endtask

  task automatic test_perf();
    ent_t z;
    logic [1:0] exp_seq [5];
    exp_seq = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b01};
    z = '0;
    do_reset();
    for (int g = 0; g < 3; g++) begin
      drive(1'b0, 2'b11, 1'b0, mk(K_OR, 5'(8 + g), 5'd20, 5'd21), mk(K_OR, 5'(12 + g), 5'd22, 5'd23));
      advance();
    end
    drive(1'b0, 2'b11, 1'b0, mk(K_ADDU, 5'd3, 5'd1, 5'd2), mk(K_SUBU, 5'd4, 5'd3, 5'd1));
    advance();
    drive(1'b0, 2'b00, 1'b1, z, z);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== exp_seq[k]) begin n_fail++; $display("FAIL perf_seq[%0d]: got %b expected %b", k, out_valid, exp_seq[k]); end
      advance();
    end
`ifdef DECODE_QUEUE_PERF_EN
    n_checks++; if (perf_dual_cnt !== 32'd3 || perf_single_cnt !== 32'd2) begin
      n_fail++; $display("FAIL perf_counts: got %0d/%0d expected 3/2", perf_dual_cnt, perf_single_cnt);
    end
`else
    n_checks++; if (perf_dual_cnt !== 32'd0 || perf_single_cnt !== 32'd0) begin
      n_fail++; $display("FAIL perf_disabled: got %0d/%0d expected 0/0", perf_dual_cnt, perf_single_cnt);
    end
`endif
    drive(1'b1, 2'b11, 1'b1, mk(K_OR, 5'd8, 5'd9, 5'd10), mk(K_OR, 5'd11, 5'd12, 5'd13));
    advance();
    drive(1'b0, 2'b00, 1'b0, z, z);
    @(negedge clk);
    n_checks++; if (perf_dual_cnt !== exp_dual() || perf_single_cnt !== exp_single()) begin
      n_fail++; $display("FAIL perf_after_flush: got %0d/%0d expected %0d/%0d", perf_dual_cnt, perf_single_cnt, exp_dual(), exp_single());
    end
    advance();
  endtask

  task automatic test_random();
    ent_t       e0, e1;
    logic [1:0] iv;
    logic       fl, ir;
    int         en, sel;
    for (int cyc = 0; cyc < 400; cyc++) begin
      sel = $urandom_range(0, 2);
      iv  = (sel == 0) ? 2'b00 : ((sel == 1) ? 2'b01 : 2'b11);
      e0  = mk($urandom_range(0, 14), rnd_reg(), rnd_reg(), rnd_reg());
      e1  = mk($urandom_range(0, 14), rnd_reg(), rnd_reg(), rnd_reg());
      fl  = ($urandom_range(0, 29) == 0);
      ir  = ($urandom_range(0, 3) != 0);
      drive(fl, iv, ir, e0, e1);
      @(negedge clk);
      en = model_n(ir, fl);
      n_checks++; if (out_valid !== mask_of(en)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", cyc, out_valid, mask_of(en)); end
      n_checks++; if (in_ready !== ((16 - q.size()) >= 2)) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", cyc, in_ready, ((16 - q.size()) >= 2)); end
      for (int s = 0; s < en; s++) begin
        n_checks++; if (out_pc[32*s +: 32] !== q[s].pc || out_instr[32*s +: 32] !== q[s].instr) begin
          n_fail++; $display("FAIL rnd_entry[%0d.%0d]: got %h/%h expected %h/%h", cyc, s, out_pc[32*s +: 32], out_instr[32*s +: 32], q[s].pc, q[s].instr);
        end
        n_checks++; if (out_reg_waddr[5*s +: 5] !== q[s].waddr || out_branch_type[4*s +: 4] !== q[s].bt) begin
          n_fail++; $display("FAIL rnd_decode[%0d.%0d]: got wa %0d bt %0d expected wa %0d bt %0d", cyc, s, out_reg_waddr[5*s +: 5], out_branch_type[4*s +: 4], q[s].waddr, q[s].bt);
        end
      end
      n_checks++; if (perf_dual_cnt !== exp_dual() || perf_single_cnt !== exp_single()) begin
        n_fail++; $display("FAIL rnd_perf[%0d]: got %0d/%0d expected %0d/%0d", cyc, perf_dual_cnt, perf_single_cnt, exp_dual(), exp_single());
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    ent_t z;
    z = '0;
    for (int g = 0; g < 2; g++) begin
      drive(1'b0, 2'b11, 1'b0, mk(K_OR, 5'd8, 5'd9, 5'd10), mk(K_OR, 5'd11, 5'd12, 5'd13));
      advance();
    end
    drive(1'b0, 2'b00, 1'b1, z, z);
    #2;
    resetn = 1'b0;
    #1;
    n_checks++; if (out_valid !== 2'b00 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid: got valid %b ready %b expected 00/1", out_valid, in_ready);
    end
    n_checks++; if (perf_dual_cnt !== 32'd0 || perf_single_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_perf: got %0d/%0d expected 0/0", perf_dual_cnt, perf_single_cnt);
    end
    q.delete();
    m_dual = 0;
    m_single = 0;
    resetn = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_mid_empty: got %b expected 00", out_valid); end
    advance();
  endtask

  initial begin
    test_reset();
    test_pair_basic();
    test_raw();
    test_branch_hold();
    test_full_wrap();
    test_flush();
    test_perf();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_decode_queue.md
Name: inst_decode_queue

Overview:
- Parametrised instruction buffer between fetch and issue.
- Accepts up to FETCH_W raw instructions per cycle into a circular queue of DEPTH entries.
- Decodes the head entries by instantiating the team's combinational decoder once per issue slot.
- Applies dual-issue pairing rules and pops 0..ISSUE_W instructions per cycle.
- Successor to single-slot decode: adds buffering, configurable width, hazard-based pairing and branch/delay-slot holding.

Parameters:
DEPTH, 16, queue entries; power of two, at least 4.
FETCH_W, 2, instructions pushed per cycle (1 or 2).
ISSUE_W, 2, issue slots (1 or 2); with 1, slot1 outputs are tied 0.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
flush  in  1  discard all entries (exception/mispredict)
in_valid  in  FETCH_W  per-slot push valid; must be contiguous from bit 0
in_instr  in  32*FETCH_W  raw instructions, slot0 in low bits
in_pc  in  32*FETCH_W  PCs
in_ready  out  1  queue can accept a full FETCH_W group
issue_ready  in  1  issue stage accepts this cycle
out_valid  out  ISSUE_W  slot issued this cycle (slot1 only if slot0)
out_instr  out  32*ISSUE_W  head instructions
out_pc  out  32*ISSUE_W  head PCs
out_aluop  out  8*ISSUE_W  decoded aluop per slot
out_reg_waddr  out  5*ISSUE_W  decoded destination register
out_branch_type  out  4*ISSUE_W  decoded branch type
perf_dual_cnt  out  32  dual-issue cycle counter (optional feature)
perf_single_cnt  out  32  single-issue cycle counter (optional feature)

Behaviour:
- Reset (asynchronous, resetn=0): rd_ptr=wr_ptr=0, count=0, out_valid=0, in_ready=1, perf counters=0.
- Storage: instr+pc per entry. Pointers are log2(DEPTH) bits and wrap modulo DEPTH; a separate count (0..DEPTH) distinguishes full from empty.
- in_ready = (DEPTH - count) >= FETCH_W. This is registered-state combinational; no partial accept.
- Push: when in_valid[0] && in_ready, write popcount(in_valid) entries at wr_ptr, wr_ptr+1. Push with in_ready=0 is ignored.
- Latency: an entry pushed in cycle N is visible at the head in cycle N+1 (no bypass).
- Head decode: slot0 = entry[rd_ptr], slot1 = entry[rd_ptr+1]; both are decoded combinationally.
- Issue count n, evaluated only when issue_ready=1 (otherwise n=0, out_valid=0):
  - count==0: n=0.
  - Slot0 branch_type != BT_NOP: needs its delay slot; if count==1, n=0 (branch held); else n=2 when ISSUE_W==2 (branch paired with delay slot), n=1 when ISSUE_W==1.
  - Otherwise n=1 if any of: ISSUE_W==1; count==1; slot1 is_only_master; slot1 branch_type != BT_NOP; slot0 reg_wen && waddr!=0 && waddr equals slot1 rs or rt; both is_hilo_accessed; both mem_en; either spec_inst or eret_inst; either undefined_inst.
  - Otherwise n=2.
- Exception: a paired branch+delay slot still issues together even if slot1 would fail the RAW check. Slot0 is a branch and does not write the register file except on link; for a link branch (is_link_pc8) writing $31 read by the delay slot, n=1. The issue stage must then hold the branch.
- Pop: rd_ptr += n; count_next = count + push_cnt - n. Simultaneous push and pop at full or empty is legal.
- Flush: synchronous; highest priority. Next cycle count=0, rd_ptr=wr_ptr=0; same-cycle push dropped, out_valid forced 0.
- Reset mid-operation: queue empties immediately; outputs return to reset values.

Optional Feature:
DECODE_QUEUE_PERF_EN
- Defined: perf_dual_cnt increments on cycles with n=2, perf_single_cnt on cycles with n=1. Both are 32-bit, saturating at 0xFFFFFFFF and cleared only by reset (not flush).
- Undefined: both ports are constant 0 and no counter flops are synthesised.

Test Plan:
- Reset, push {addu $3,$1,$2 ; or $5,$4,$6}, issue_ready=1 -> next cycle out_valid=2'b11, count 2->0.
- Push {addu $3,$1,$2 ; subu $4,$3,$1} -> cycle 1 out_valid=2'b01 (RAW on $3); cycle 2 slot1 issues alone.
- Push only beq (single) -> out_valid=0 while count==1; push delay slot next cycle -> out_valid=2'b11 with beq at slot0.
- Push 8 groups of 2 with issue_ready=0 (DEPTH=16) -> in_ready drops to 0 at count=16; further pushes ignored; then drain -> PCs emerge in order across wrap.
- With count=6, assert flush together with a push -> next cycle count=0, out_valid=0, in_ready=1.
- With DECODE_QUEUE_PERF_EN: 3 dual and 2 single issue cycles -> perf_dual_cnt=3, perf_single_cnt=2; unchanged after flush.
